eth_frame_gen: RTL
==================

// Module: eth_frame_gen
// PURPOSE
//  Parametrised Ethernet frame generator driving eth_axis_tx header + payload streams.
//  Replaces hand-coded bench stimulus with a programmable source: pattern mode, payload length,
//  frame count, inter-frame gap, full ready/valid compliance. Usable in sim and as on-chip MAC loopback source.
// PARAMETERS
//  DATA_WIDTH  8    payload tdata width, multiple of 8
//  KEEP_WIDTH  DATA_WIDTH/8  tkeep width
//  LEN_WIDTH   16   payload length field width (bytes)
//  CNT_WIDTH   16   frame count / frames_sent width
//  GAP_WIDTH   16   inter-frame gap counter width (cycles)
// PORTS
//  clk                        in   1   clock
//  rst_n                      in   1   asynchronous reset, active low
//  start / stop               in   1   start run (IDLE only) / end run at next frame boundary
//  cfg_dest_mac, cfg_src_mac  in   48  header MACs
//  cfg_eth_type               in   16  header ethertype
//  cfg_payload_len            in   LEN_WIDTH  payload bytes per frame; 0 treated as 1
//  cfg_frame_count            in   CNT_WIDTH  frames per run; 0 = continuous until stop
//  cfg_mode                   in   2   0 INC, 1 DEC, 2 CONST, 3 PRBS
//  cfg_seed, cfg_step         in   8   first byte value / per-byte step
//  cfg_gap                    in   GAP_WIDTH  idle cycles between frames
//  m_eth_hdr_valid            out  1   header valid;  m_eth_hdr_ready in 1
//  m_eth_dest_mac, m_eth_src_mac out 48; m_eth_type out 16  latched header
//  m_eth_payload_axis_tdata/tkeep/tvalid/tlast/tuser  out  payload stream; tready in 1
//  busy                       out  1   high in any state but IDLE
//  done                       out  1   one-cycle pulse on return to IDLE
//  frames_sent                out  CNT_WIDTH  frames completed this run
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; internal counters 0.
//  - FSM IDLE -> HDR -> PAYLOAD -> GAP -> (HDR | IDLE).
//  - IDLE: start=1 & stop=0 latches all cfg_* into shadow regs, clears frames_sent, -> HDR next cycle.
//    start with stop same cycle ignored; start outside IDLE ignored; cfg_* changes mid-run ignored.
//  - HDR: m_eth_hdr_valid=1, header fields from shadow regs, stable until hdr_ready; handshake -> PAYLOAD.
//  - PAYLOAD: beats = ceil(len/KEEP_WIDTH). tvalid held 1; tdata/tkeep/tlast stable while tready=0.
//    Byte k of payload (k=0..len-1, byte lane = k mod KEEP_WIDTH, LSB lane first):
//    INC: seed+k*step; DEC: seed-k*step; CONST: seed (all mod 256);
//    PRBS: Fibonacci LFSR x^8+x^6+x^5+x^4+1, one advance per byte, byte0 = seed (seed 0 -> 8'hFF).
//    tkeep all ones except last beat: low (len mod KEEP_WIDTH) bits, all ones if remainder 0.
//    tlast=1 on final beat only; tuser always 0. Per-beat byte counter wraps never (LEN_WIDTH sized).
//  - tlast handshake: frames_sent+1 (saturates at all-ones); -> GAP.
//  - GAP: counts cfg_gap cycles with all valids 0 (gap 0 = zero cycles, next HDR immediately after tlast beat).
//    End of GAP: if stop seen since run start, or frames_sent==cfg_frame_count (count!=0) -> IDLE, done=1
//    for one cycle; else -> HDR with pattern restarted at byte 0 (PRBS reseeded).
//  - stop: sticky flag, checked only at GAP exit; never truncates a frame in flight.
//  - Reset mid-frame: stream abandoned immediately (tvalid drops); downstream must tolerate.
//  - Latency: start -> hdr_valid 1 cycle; hdr handshake -> first tvalid 1 cycle; full-throughput beats when tready=1.
// TESTING
//  1. DATA_WIDTH=8, len=64, INC seed 0 step 1, count 1, gap 0, ready=1 -> one frame, bytes 0..63, tlast on 64th beat, done, frames_sent=1.
//  2. DEC seed 120 step 5, len 22, count 1 -> bytes 120,115,...,15; tlast on 22nd; MAC pads to 60 on wire.
//  3. DATA_WIDTH=32, len=7, CONST seed 8'hA5 -> 2 beats, tkeep 4'hF then 4'h7, tlast on beat 2.
//  4. Random tready/hdr_ready stalls, PRBS seed 8'h01, count 3, gap 12 -> data stable under stall,
//     byte seq 01,02,04,08,11,23,... per frame, >=12 idle cycles between frames, frames_sent=3.
//  5. count 0 continuous, stop asserted mid-frame 2 -> frame 2 completes intact, then IDLE, done, frames_sent=2.
//  6. rst_n low mid-payload -> all outputs 0 same cycle; start after release runs cleanly from byte 0.

Source files
------------

// File: rtl/eth_frame_gen.sv
// eth_frame_gen: programmable Ethernet frame source. Emits one header beat on
// the m_eth_hdr_* channel followed by a patterned payload on the AXI-stream
// channel. It repeats for a configured number of frames, or until stop, with
// an optional idle gap between frames.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. Once valid is raised it stays high and
// every payload/header field stays constant until that transfer. Valid never
// depends combinationally on ready.
module eth_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [47:0]           cfg_dest_mac,
  input  logic [47:0]           cfg_src_mac,
  input  logic [15:0]           cfg_eth_type,
  input  logic [LEN_WIDTH-1:0]  cfg_payload_len,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_count,
  input  logic [1:0]            cfg_mode,
  input  logic [7:0]            cfg_seed,
  input  logic [7:0]            cfg_step,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [1:0]            fsm_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam logic [1:0] M_INC   = 2'd0;
  localparam logic [1:0] M_DEC   = 2'd1;
  localparam logic [1:0] M_CONST = 2'd2;

  localparam logic [LEN_WIDTH:0] KW = (LEN_WIDTH + 1)'(KEEP_WIDTH);

  logic [1:0]            state;
  logic [1:0]            mode_q;
  logic [7:0]            seed_q;
  logic [7:0]            step_q;
  logic [7:0]            base_q;      // pattern value of lane 0 in the current beat
  logic [CNT_WIDTH-1:0]  count_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [LEN_WIDTH-1:0]  beat_idx;
  logic [LEN_WIDTH-1:0]  last_beat_q;
  logic [KEEP_WIDTH-1:0] keep_last_q;
  logic                  stop_seen;

  // PRBS x^8+x^6+x^5+x^4+1, Fibonacci form, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // An all-zero PRBS seed would lock the LFSR, so it is replaced by 8'hFF.
  function automatic logic [7:0] first_byte(input logic [1:0] mode, input logic [7:0] seed);
    return (mode == 2'd3 && seed == 8'h00) ? 8'hFF : seed;
  endfunction

  logic [LEN_WIDTH:0]    len_eff;
  logic [LEN_WIDTH:0]    rem;
  logic [LEN_WIDTH-1:0]  beats_m1;
  logic [KEEP_WIDTH-1:0] keep_tail;

  // Frame geometry from the live config, captured only when a run starts.
  always_comb begin
    len_eff  = (cfg_payload_len == '0) ? (LEN_WIDTH + 1)'(1) : {1'b0, cfg_payload_len};
    beats_m1 = LEN_WIDTH'((len_eff + KW - 1'b1) / KW - 1'b1);
    rem      = len_eff % KW;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      keep_tail[i] = (rem == '0) || ((LEN_WIDTH + 1)'(i) < rem);
    end
  end

  logic [DATA_WIDTH-1:0] beat_data;
  logic [7:0]            next_base;
  logic [7:0]            lane_v;

  // Expand the lane-0 value across all byte lanes; the value after the last lane seeds the next beat.
  always_comb begin
    lane_v    = base_q;
    beat_data = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_data[i*8 +: 8] = lane_v;
      case (mode_q)
        M_INC:   lane_v = lane_v + step_q;
        M_DEC:   lane_v = lane_v - step_q;
        M_CONST: lane_v = base_q;
        default: lane_v = lfsr_next(lane_v);
      endcase
    end
    next_base = lane_v;
  end

  logic                 hdr_fire;
  logic                 beat_fire;
  logic                 last_fire;
  logic [CNT_WIDTH-1:0] frames_next;
  logic                 end_after_payload;
  logic                 end_after_gap;

  // Transfer strobes and run-termination decisions.
  always_comb begin
    hdr_fire          = (state == S_HDR) && m_eth_hdr_ready;
    beat_fire         = (state == S_PAYLOAD) && m_eth_payload_axis_tready;
    last_fire         = beat_fire && (beat_idx == last_beat_q);
    frames_next       = (&frames_sent) ? frames_sent : frames_sent + 1'b1;
    end_after_payload = stop_seen || stop || (count_q != '0 && frames_next == count_q);
    end_after_gap     = stop_seen || stop || (count_q != '0 && frames_sent == count_q);
  end

  // Outputs derived from registered state so an async reset clears them at once.
  always_comb begin
    fsm_state                 = state;
    busy                      = (state != S_IDLE);
    m_eth_hdr_valid           = (state == S_HDR);
    m_eth_payload_axis_tvalid = (state == S_PAYLOAD);
    m_eth_payload_axis_tlast  = (state == S_PAYLOAD) && (beat_idx == last_beat_q);
    m_eth_payload_axis_tuser  = 1'b0;
    m_eth_payload_axis_tdata  = (state == S_PAYLOAD) ? beat_data : '0;
    m_eth_payload_axis_tkeep  = '0;
    if (state == S_PAYLOAD) begin
      m_eth_payload_axis_tkeep = m_eth_payload_axis_tlast ? keep_last_q : '1;
    end
  end

  // Frame sequencer: IDLE -> HDR -> PAYLOAD -> GAP -> (HDR | IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      mode_q         <= '0;
      seed_q         <= '0;
      step_q         <= '0;
      base_q         <= '0;
      count_q        <= '0;
      gap_q          <= '0;
      gap_cnt        <= '0;
      beat_idx       <= '0;
      last_beat_q    <= '0;
      keep_last_q    <= '0;
      stop_seen      <= 1'b0;
      m_eth_dest_mac <= '0;
      m_eth_src_mac  <= '0;
      m_eth_type     <= '0;
      frames_sent    <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && stop) begin
        stop_seen <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            mode_q         <= cfg_mode;
            seed_q         <= cfg_seed;
            step_q         <= cfg_step;
            base_q         <= first_byte(cfg_mode, cfg_seed);
            count_q        <= cfg_frame_count;
            gap_q          <= cfg_gap;
            last_beat_q    <= beats_m1;
            keep_last_q    <= keep_tail;
            beat_idx       <= '0;
            stop_seen      <= 1'b0;
            m_eth_dest_mac <= cfg_dest_mac;
            m_eth_src_mac  <= cfg_src_mac;
            m_eth_type     <= cfg_eth_type;
            frames_sent    <= '0;
            state          <= S_HDR;
          end
        end
        S_HDR: begin
          if (hdr_fire) begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (beat_fire) begin
            beat_idx <= beat_idx + 1'b1;
            base_q   <= next_base;
          end
          if (last_fire) begin
            frames_sent <= frames_next;
            beat_idx    <= '0;
            base_q      <= first_byte(mode_q, seed_q);
            if (gap_q != '0) begin
              gap_cnt <= gap_q;
              state   <= S_GAP;
            end else if (end_after_payload) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_HDR;
            end
          end
        end
        default: begin
          if (gap_cnt <= GAP_WIDTH'(1)) begin
            gap_cnt <= '0;
            if (end_after_gap) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_HDR;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule
